logo_motion_ctrl: RTL and testbench
===================================

# logo_motion_ctrl

Frame-rate motion scheduler for the bouncing Zero-to-ASIC logo. Once per video frame it advances the logo's top-left position by a programmable step and reflects direction at the screen edges. It advances the colour index on every bounce and commits the new position atomically, so the pixel pipeline never sees a half-updated coordinate. It sits between the VGA timing generator, which supplies `frame_tick`, and the logo renderer, which consumes `logo_x`, `logo_y` and `color_idx`.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines.
- `LOGO_W`, 64: logo width in pixels.
- `LOGO_H`, 64: logo height in pixels.
- `INIT_X`, 288: reset x position.
- `INIT_Y`, 208: reset y position.

Ports:
- `clk`  in  1  pixel clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `frame_tick`  in  1  one-cycle pulse at start of vertical blanking.
- `pause`  in  1  high: frame ticks ignored, position frozen.
- `speed`  in  2  step size; pixels per frame = `speed`+1.
- `logo_x`  out  10  committed x of logo top-left.
- `logo_y`  out  10  committed y of logo top-left.
- `color_idx`  out  3  committed palette index.
- `bounce`  out  1  one-cycle pulse on commit when either axis reflected.
- `corner`  out  1  one-cycle pulse on commit when both axes reflected.
- `busy`  out  1  high while an update is in flight.

## Operation
- Limits: XMAX = `H_ACTIVE`-`LOGO_W`; YMAX = `V_ACTIVE`-`LOGO_H`. Position range is 0..XMAX and 0..YMAX.
- Internal state: shadow `sx`, `sy`; direction bits `dx`, `dy` (1 = increasing); flags `hit_x`, `hit_y`.
- FSM states: WAIT, STEP_X, STEP_Y, COMMIT.
  - WAIT → STEP_X when `frame_tick`=1 and `pause`=0. Otherwise stay in WAIT.
  - STEP_X → STEP_Y → COMMIT → WAIT, unconditionally.
- `speed` is latched as `step` on leaving WAIT. It is constant for the whole update.
- STEP_X, increasing direction (`dx`=1):
  - if `sx`+`step` ≥ XMAX: `sx`=XMAX, `dx`=0, `hit_x`=1.
  - else: `sx`+=`step`.
- STEP_X, decreasing direction (`dx`=0):
  - if `sx` ≤ `step`: `sx`=0, `dx`=1, `hit_x`=1.
  - else: `sx`-=`step`.
- The position clamps at the edge; it is never reflected past it. Sums are computed at 11 bits, so there is no wrap.
- STEP_Y: identical rules using `sy`, `dy`, YMAX and `hit_y`.
- COMMIT:
  - `logo_x`←`sx`, `logo_y`←`sy`.
  - If `hit_x`|`hit_y`: `color_idx`←`color_idx`+1 mod 8.
  - Pulse `bounce` = `hit_x`|`hit_y`; pulse `corner` = `hit_x`&`hit_y`.
  - Clear both hit flags.
- A `frame_tick` arriving outside WAIT is dropped. It is neither queued nor counted.
- `pause` is sampled only in WAIT. An update already in flight always completes.
- Reset (async, any state):
  - FSM=WAIT.
  - `logo_x`=`sx`=`INIT_X`, `logo_y`=`sy`=`INIT_Y`.
  - `dx`=`dy`=1, `color_idx`=0.
  - `bounce`=`corner`=`busy`=0; hit flags=0.
- A reset mid-update abandons the update. No partial commit is visible.

## Timing
- Cycle 0: `frame_tick` high, FSM in WAIT.
- Cycles 1–3: STEP_X, STEP_Y, COMMIT; `busy`=1 in exactly these cycles.
- Cycle 4: new `logo_x`, `logo_y` and `color_idx` are visible. `bounce`/`corner` are high for cycle 4 only.
- Latency from tick to committed outputs is 4 cycles.
- `logo_x` and `logo_y` change on the same edge; they never change on different edges.
- All outputs are registered.
- Back-to-back ticks 4 or more cycles apart are all serviced.

## Structure
- Shared package `zta_screensaver_pkg` holds:
  - `H_ACTIVE`, `V_ACTIVE`, `LOGO_W`, `LOGO_H` defaults;
  - the coordinate width constant (10);
  - the FSM state enum type.
- Sub-module `axis_stepper`: combinational next-position, next-direction and hit calculation for one axis (pos, dir, step, max). It is instantiated twice, for x and y. The FSM enables each instance's register update in its own step state.

## Test plan
- Reset with `INIT_X`=288, `INIT_Y`=208 → `logo_x`=288, `logo_y`=208, `color_idx`=0, `busy`=0, no pulses.
- `speed`=3, one tick → cycle 4 shows `logo_x`=292, `logo_y`=212; `busy` high in cycles 1–3 only; `bounce`=0.
- Preload via ticks to `logo_x`=574 with `dx`=1, `speed`=3, then tick → `logo_x`=576, `bounce`=1 for one cycle, `color_idx`+1. Next tick → `logo_x`=572.
- Drive the logo to `logo_x`=576, `logo_y`=416 with both hitting on the same frame → `corner`=1 and `bounce`=1 in the same cycle; `color_idx` increments by exactly 1.
- `pause`=1 during 10 ticks → outputs unchanged, `busy` never high. Also: tick at cycle 0 plus a second tick at cycle 2 → exactly one update.
- Assert `rst` during STEP_Y → outputs return to reset values asynchronously, with no commit. After release, the next tick updates from `INIT_X`/`INIT_Y`.

Source files
------------

// File: rtl/zta_screensaver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zta_screensaver_pkg
// Purpose  : Shared constants and types for the bouncing-logo screensaver.
//            Holds the default screen and logo geometry, the coordinate width
//            and the motion-scheduler FSM state type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package zta_screensaver_pkg;

  localparam int c_H_ACTIVE = 640;  // visible pixels per line
  localparam int c_V_ACTIVE = 480;  // visible lines
  localparam int c_LOGO_W   = 64;   // logo width in pixels
  localparam int c_LOGO_H   = 64;   // logo height in pixels
  localparam int c_COORD_W  = 10;   // width of a screen coordinate
  localparam int c_STEP_W   = 3;    // width of a per-frame step (1..4)

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_STEP_X = 2'd1,
    ST_STEP_Y = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/logo_motion_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : logo_motion_ctrl_if
// Purpose  : Bundles the controls coming from the VGA timing side and the
//            committed logo position/colour going to the renderer.
// Ports    : frame_tick, pause, speed      (timing side -> controller)
//            logo_x, logo_y, color_idx,
//            bounce, corner, busy          (controller -> renderer)
//            modport master : drives the controls, observes the outputs
//            modport slave  : the motion controller itself
// Revision : 1.0 - initial release
// ============================================================================
interface logo_motion_ctrl_if;
  import zta_screensaver_pkg::*;

  logic                 frame_tick;
  logic                 pause;
  logic [1:0]           speed;
  logic [c_COORD_W-1:0] logo_x;
  logic [c_COORD_W-1:0] logo_y;
  logic [2:0]           color_idx;
  logic                 bounce;
  logic                 corner;
  logic                 busy;

  modport master (
    output frame_tick, pause, speed,
    input  logo_x, logo_y, color_idx, bounce, corner, busy
  );

  modport slave (
    input  frame_tick, pause, speed,
    output logo_x, logo_y, color_idx, bounce, corner, busy
  );

endinterface
`default_nettype wire

// File: rtl/logo_motion_ctrl_axis_stepper.sv
`default_nettype none
// ============================================================================
// Module   : axis_stepper
// Purpose  : Combinational next position / direction / hit for one axis.
//            Moving up, the position clamps at i_max; moving down, it clamps
//            at 0. Either clamp reverses direction and raises o_hit.
// Ports    : i_pos  current position      i_dir  1 = increasing
//            i_step step size (1..4)      i_max  upper limit of the axis
//            o_pos  next position         o_dir  next direction
//            o_hit  edge reached this step
// Revision : 1.0 - initial release
// ============================================================================
module axis_stepper
  import zta_screensaver_pkg::*;
#(
  parameter int COORD_W = c_COORD_W,
  parameter int STEP_W  = c_STEP_W
) (
  input  wire logic [COORD_W-1:0] i_pos,
  input  wire logic               i_dir,
  input  wire logic [STEP_W-1:0]  i_step,
  input  wire logic [COORD_W-1:0] i_max,
  output logic      [COORD_W-1:0] o_pos,
  output logic                    o_dir,
  output logic                    o_hit
);

  // One extra bit so pos+step can never wrap before the compare.
  logic [COORD_W:0] w_step_ext;
  logic [COORD_W:0] w_sum;

  assign w_step_ext = {{(COORD_W+1-STEP_W){1'b0}}, i_step};
  assign w_sum      = {1'b0, i_pos} + w_step_ext;

  always_comb begin
    o_pos = i_pos;
    o_dir = i_dir;
    o_hit = 1'b0;
    if (i_dir) begin
      if (w_sum >= {1'b0, i_max}) begin
        o_pos = i_max;
        o_dir = 1'b0;
        o_hit = 1'b1;
      end else begin
        o_pos = w_sum[COORD_W-1:0];
      end
    end else begin
      if ({1'b0, i_pos} <= w_step_ext) begin
        o_pos = '0;
        o_dir = 1'b1;
        o_hit = 1'b1;
      end else begin
        o_pos = i_pos - w_step_ext[COORD_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/logo_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : logo_motion_ctrl
// Purpose  : Once-per-frame motion scheduler for the bouncing logo. On an
//            accepted frame tick it steps x, then y, in a shadow copy and
//            commits both coordinates (and the bounce colour change) on a
//            single edge so the renderer never sees a half-updated position.
// Ports    : clk  pixel clock
//            rst  asynchronous active-high reset
//            bus  logo_motion_ctrl_if.slave (frame_tick, pause, speed in;
//                 logo_x, logo_y, color_idx, bounce, corner, busy out)
// Revision : 1.0 - initial release
// ============================================================================
module logo_motion_ctrl
  import zta_screensaver_pkg::*;
#(
  parameter int H_ACTIVE = c_H_ACTIVE,
  parameter int V_ACTIVE = c_V_ACTIVE,
  parameter int LOGO_W   = c_LOGO_W,
  parameter int LOGO_H   = c_LOGO_H,
  parameter int INIT_X   = 288,
  parameter int INIT_Y   = 208
) (
  input wire logic          clk,
  input wire logic          rst,
  logo_motion_ctrl_if.slave bus
);

  localparam logic [c_COORD_W-1:0] c_XMAX   = c_COORD_W'(H_ACTIVE - LOGO_W);
  localparam logic [c_COORD_W-1:0] c_YMAX   = c_COORD_W'(V_ACTIVE - LOGO_H);
  localparam logic [c_COORD_W-1:0] c_INIT_X = c_COORD_W'(INIT_X);
  localparam logic [c_COORD_W-1:0] c_INIT_Y = c_COORD_W'(INIT_Y);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_leave_wait;
  logic   w_en_x;
  logic   w_en_y;
  logic   w_commit;

  logic [c_STEP_W-1:0]  r_step;
  logic [c_COORD_W-1:0] r_sx, r_sy;
  logic                 r_dx, r_dy;
  logic                 r_hit_x, r_hit_y;
  logic [c_COORD_W-1:0] r_logo_x, r_logo_y;
  logic [2:0]           r_color;
  logic                 r_bounce, r_corner, r_busy;

  logic [c_COORD_W-1:0] w_sx_nxt, w_sy_nxt;
  logic                 w_dx_nxt, w_dy_nxt;
  logic                 w_hit_x, w_hit_y;

  axis_stepper #(.COORD_W(c_COORD_W), .STEP_W(c_STEP_W)) u_step_x (
    .i_pos  (r_sx),
    .i_dir  (r_dx),
    .i_step (r_step),
    .i_max  (c_XMAX),
    .o_pos  (w_sx_nxt),
    .o_dir  (w_dx_nxt),
    .o_hit  (w_hit_x)
  );

  axis_stepper #(.COORD_W(c_COORD_W), .STEP_W(c_STEP_W)) u_step_y (
    .i_pos  (r_sy),
    .i_dir  (r_dy),
    .i_step (r_step),
    .i_max  (c_YMAX),
    .o_pos  (w_sy_nxt),
    .o_dir  (w_dy_nxt),
    .o_hit  (w_hit_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ticks and pause are only looked at in WAIT, so a tick arriving while an
  // update is in flight is simply dropped.
  always_comb begin
    w_state_nxt  = r_state;
    w_leave_wait = 1'b0;
    w_en_x       = 1'b0;
    w_en_y       = 1'b0;
    w_commit     = 1'b0;
    unique case (r_state)
      ST_WAIT: begin
        if (bus.frame_tick && !bus.pause) begin
          w_state_nxt  = ST_STEP_X;
          w_leave_wait = 1'b1;
        end
      end
      ST_STEP_X: begin
        w_en_x      = 1'b1;
        w_state_nxt = ST_STEP_Y;
      end
      ST_STEP_Y: begin
        w_en_y      = 1'b1;
        w_state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      default: w_state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step   <= c_STEP_W'(1);
      r_sx     <= c_INIT_X;
      r_sy     <= c_INIT_Y;
      r_dx     <= 1'b1;
      r_dy     <= 1'b1;
      r_hit_x  <= 1'b0;
      r_hit_y  <= 1'b0;
      r_logo_x <= c_INIT_X;
      r_logo_y <= c_INIT_Y;
      r_color  <= 3'd0;
      r_bounce <= 1'b0;
      r_corner <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      // busy mirrors the next state so it is high exactly in STEP_X..COMMIT.
      r_busy   <= (w_state_nxt != ST_WAIT);
      r_bounce <= w_commit & (r_hit_x | r_hit_y);
      r_corner <= w_commit & r_hit_x & r_hit_y;

      if (w_leave_wait) begin
        r_step <= {1'b0, bus.speed} + c_STEP_W'(1);
      end
      if (w_en_x) begin
        r_sx    <= w_sx_nxt;
        r_dx    <= w_dx_nxt;
        r_hit_x <= r_hit_x | w_hit_x;
      end
      if (w_en_y) begin
        r_sy    <= w_sy_nxt;
        r_dy    <= w_dy_nxt;
        r_hit_y <= r_hit_y | w_hit_y;
      end
      if (w_commit) begin
        r_logo_x <= r_sx;
        r_logo_y <= r_sy;
        r_hit_x  <= 1'b0;
        r_hit_y  <= 1'b0;
        if (r_hit_x | r_hit_y) begin
          r_color <= r_color + 3'd1;
        end
      end
    end
  end

  assign bus.logo_x    = r_logo_x;
  assign bus.logo_y    = r_logo_y;
  assign bus.color_idx = r_color;
  assign bus.bounce    = r_bounce;
  assign bus.corner    = r_corner;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_logo_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_logo_motion_ctrl
// Purpose  : Scoreboard bench for logo_motion_ctrl. A frame-level model turns
//            each accepted tick into an expected committed state; a monitor
//            pops it when the DUT finishes an update and otherwise checks
//            that the outputs hold. A second instance started near the
//            bottom-right corner exercises the simultaneous two-axis bounce.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logo_motion_ctrl;

  localparam int c_XMAX = 576;
  localparam int c_YMAX = 416;

  typedef struct {
    int x;
    int y;
    int col;
    bit b;
    bit c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logo_motion_ctrl_if bus   ();
  logo_motion_ctrl_if bus_c ();

  logo_motion_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logo_motion_ctrl #(.INIT_X(500), .INIT_Y(340)) dut_c (
    .clk (clk),
    .rst (rst),
    .bus (bus_c.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  int m_x, m_y, m_col;
  bit m_dx, m_dy;
  int edge_cnt = 0;
  int last_acc = -100;
  exp_t q[$];

  always @(posedge clk) edge_cnt++;

  // Move by +/-step; reaching or passing an edge clamps to it and reverses.
  function automatic void adv(input int pos, input bit dir, input int st,
                              input int mx, output int npos, output bit ndir,
                              output bit hit);
    int p;
    p = dir ? pos + st : pos - st;
    hit  = (p <= 0) || (p >= mx);
    npos = (p <= 0) ? 0 : ((p >= mx) ? mx : p);
    ndir = hit ? ~dir : dir;
  endfunction

  task automatic model_reset();
    m_x = 288; m_y = 208; m_col = 0; m_dx = 1'b1; m_dy = 1'b1;
    last_acc = -100;
  endtask

  // One cycle of stimulus; the values are sampled by the next rising edge.
  task automatic drive(input bit t, input bit p, input int s);
    int sample_edge;
    bit hx, hy;
    exp_t e;
    @(posedge clk);
    #1;
    bus.frame_tick = t;
    bus.pause      = p;
    bus.speed      = 2'(s);
    sample_edge    = edge_cnt + 1;
    if (t && !p && (sample_edge - last_acc >= 4)) begin
      last_acc = sample_edge;
      adv(m_x, m_dx, s + 1, c_XMAX, m_x, m_dx, hx);
      adv(m_y, m_dy, s + 1, c_YMAX, m_y, m_dy, hy);
      if (hx || hy) m_col = (m_col + 1) % 8;
      e.x = m_x; e.y = m_y; e.col = m_col; e.b = hx | hy; e.c = hx & hy;
      q.push_back(e);
    end
  endtask

  // ---------------- monitor ----------------
  int   last_x = 288, last_y = 208, last_col = 0;
  bit   prev_busy = 1'b0;
  int   busy_run  = 0;
  exp_t m_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
      busy_run  = 0;
    end else begin
      if (prev_busy && !bus.busy) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_commit: got x=%0d y=%0d, expected no update",
                   bus.logo_x, bus.logo_y);
        end else begin
          m_e = q.pop_front();
          check("commit_x", bus.logo_x, m_e.x);
          check("commit_y", bus.logo_y, m_e.y);
          check("commit_color", bus.color_idx, m_e.col);
          check("commit_bounce", bus.bounce, m_e.b);
          check("commit_corner", bus.corner, m_e.c);
          check("busy_cycles", busy_run, 3);
          last_x = m_e.x; last_y = m_e.y; last_col = m_e.col;
        end
        busy_run = 0;
      end else begin
        check("hold_x", bus.logo_x, last_x);
        check("hold_y", bus.logo_y, last_y);
        check("hold_color", bus.color_idx, last_col);
        check("idle_bounce", bus.bounce, 0);
        check("idle_corner", bus.corner, 0);
      end
      if (bus.busy) busy_run++;
      prev_busy = bus.busy;
    end
  end

  // corner-instance pulse counters
  int c_corner_cnt = 0, c_bounce_cnt = 0, c_both_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_c.corner) c_corner_cnt++;
      if (bus_c.bounce) c_bounce_cnt++;
      if (bus_c.corner && bus_c.bounce) c_both_cnt++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"}, bus.logo_x, 288);
    check({tag, "_y"}, bus.logo_y, 208);
    check({tag, "_color"}, bus.color_idx, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_bounce"}, bus.bounce, 0);
    check({tag, "_corner"}, bus.corner, 0);
  endtask

  task automatic corner_tick();
    @(posedge clk); #1;
    bus_c.frame_tick = 1'b1;
    bus_c.speed      = 2'd3;
    @(posedge clk); #1;
    bus_c.frame_tick = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    bus.frame_tick   = 1'b0; bus.pause   = 1'b0; bus.speed   = 2'd0;
    bus_c.frame_tick = 1'b0; bus_c.pause = 1'b0; bus_c.speed = 2'd0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // single tick at speed 3, then climb x toward the right edge
    drive(1, 0, 3);
    repeat (4) drive(0, 0, 0);
    repeat (70) begin
      drive(1, 0, 3);
      repeat (3) drive(0, 0, int'($urandom_range(0, 3)));
    end
    drive(1, 0, 1);                       // x = 574
    repeat (3) drive(0, 0, 0);
    drive(1, 0, 3);                       // clamps at 576, bounces
    repeat (3) drive(0, 0, 0);
    drive(1, 0, 3);                       // back to 572
    repeat (4) drive(0, 0, 0);

    // extra ticks two and three cycles into an update are dropped
    drive(1, 0, 2);
    drive(0, 0, 2);
    drive(1, 0, 2);
    drive(1, 0, 2);
    repeat (4) drive(0, 0, 0);

    // paused ticks never start an update
    repeat (10) begin
      drive(1, 1, int'($urandom_range(0, 3)));
      repeat (2) drive(0, 1, 0);
    end
    repeat (2) drive(0, 0, 0);

    // randomized ticks, pauses and speeds
    repeat (400) begin
      drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 3)));
    end
    repeat (6) drive(0, 0, 0);

    // reset asserted while the FSM is in STEP_Y
    drive(1, 0, 3);
    @(posedge clk);                       // now STEP_X
    #1 bus.frame_tick = 1'b0;
    @(posedge clk);                       // now STEP_Y
    #2 rst = 1'b1;
    if (q.size() != 0) void'(q.pop_back());
    model_reset();
    last_x = 288; last_y = 208; last_col = 0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) drive(0, 0, 0);
    drive(1, 0, 3);                       // expect 292/212 from the init point
    repeat (6) drive(0, 0, 0);

    w = 0;
    while (q.size() != 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    check("scoreboard_drained", q.size(), 0);

    // corner instance: (500,340) + 19 steps of 4 lands on (576,416)
    repeat (19) corner_tick();
    check("corner_x", bus_c.logo_x, 576);
    check("corner_y", bus_c.logo_y, 416);
    check("corner_color", bus_c.color_idx, 1);
    check("corner_pulses", c_corner_cnt, 1);
    check("corner_bounce_pulses", c_bounce_cnt, 1);
    check("corner_with_bounce", c_both_cnt, 1);
    corner_tick();
    check("after_corner_x", bus_c.logo_x, 572);
    check("after_corner_y", bus_c.logo_y, 412);
    check("after_corner_color", bus_c.color_idx, 1);
    check("after_corner_pulses", c_corner_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
